// File: rtl/io_port_ctrl.sv
// Memory-mapped I/O port controller: output registers, synchronised inputs,
// sticky rising-edge flags with per-bit masks and a combined irq line.
module io_port_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int N_OUT  = 4,
    parameter int N_IN   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    input  logic [N_IN*DATA_W-1:0]   fpga_in,
    output logic [N_OUT*DATA_W-1:0]  fpga_out,
    output logic                     irq
);

    localparam int GW = ADDR_W - 4;

    logic [DATA_W-1:0] out_q   [N_OUT];
    logic [DATA_W-1:0] sync1_q [N_IN];
    logic [DATA_W-1:0] sync2_q [N_IN];
    logic [DATA_W-1:0] prev_q  [N_IN];
    logic [DATA_W-1:0] flag_q  [N_IN];
    logic [DATA_W-1:0] mask_q  [N_IN];
    logic [DATA_W-1:0] flag_nxt[N_IN];
    logic [DATA_W-1:0] rd_mux;
    logic [1:0]        arm_q;
    logic              armed;

    logic [GW-1:0] grp;
    logic [3:0]    idx;
    logic          grp_out, grp_in, grp_flag, grp_mask;

    assign grp      = addr[ADDR_W-1:4];
    assign idx      = addr[3:0];
    assign grp_out  = (grp == GW'(0));
    assign grp_in   = (grp == GW'(1));
    assign grp_flag = (grp == GW'(2));
    assign grp_mask = (grp == GW'(3));
    assign armed    = (arm_q == 2'd3);

    // Out-of-range channels simply never match, so they read as zero.
    always_comb begin
        rd_mux = '0;
        unique case (1'b1)
            grp_out:
                for (int k = 0; k < N_OUT; k++)
                    if (idx == 4'(k)) rd_mux = out_q[k];
            grp_in:
                for (int k = 0; k < N_IN; k++)
                    if (idx == 4'(k)) rd_mux = sync2_q[k];
            grp_flag:
                for (int k = 0; k < N_IN; k++)
                    if (idx == 4'(k)) rd_mux = flag_q[k];
            grp_mask:
                for (int k = 0; k < N_IN; k++)
                    if (idx == 4'(k)) rd_mux = mask_q[k];
            default: rd_mux = '0;
        endcase
    end

    // Hardware set is OR-ed in after the clear, so a same-cycle set wins.
    always_comb begin
        for (int k = 0; k < N_IN; k++) begin
            logic [DATA_W-1:0] clr;
            logic [DATA_W-1:0] rise;
            clr  = (wr_en && grp_flag && idx == 4'(k)) ? wr_data : '0;
            rise = armed ? (sync2_q[k] & ~prev_q[k]) : '0;
            flag_nxt[k] = (flag_q[k] & ~clr) | rise;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N_OUT; k++) out_q[k] <= '0;
            for (int k = 0; k < N_IN; k++) begin
                sync1_q[k] <= '0;
                sync2_q[k] <= '0;
                prev_q[k]  <= '0;
                flag_q[k]  <= '0;
                mask_q[k]  <= '0;
            end
            arm_q    <= 2'd0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= rd_mux;
            if (!armed) arm_q <= arm_q + 2'd1;
            for (int k = 0; k < N_OUT; k++)
                if (wr_en && grp_out && idx == 4'(k))
                    out_q[k] <= wr_data;
            for (int k = 0; k < N_IN; k++) begin
                sync1_q[k] <= fpga_in[k*DATA_W +: DATA_W];
                sync2_q[k] <= sync1_q[k];
                prev_q[k]  <= sync2_q[k];
                flag_q[k]  <= flag_nxt[k];
                if (wr_en && grp_mask && idx == 4'(k))
                    mask_q[k] <= wr_data;
            end
        end
    end

    always_comb begin
        fpga_out = '0;
        for (int k = 0; k < N_OUT; k++)
            fpga_out[k*DATA_W +: DATA_W] = out_q[k];
    end

    always_comb begin
        irq = 1'b0;
        for (int k = 0; k < N_IN; k++)
            irq = irq | (|(flag_q[k] & mask_q[k]));
    end

endmodule

// File: tb/tb_io_port_ctrl.sv
// Bench for io_port_ctrl: directed vector table followed by random
// traffic compared against a pin-history reference model.
module tb_io_port_ctrl;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int NO = 4;
    localparam int NI = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              wr_en = 1'b0;
    logic              rd_en = 1'b0;
    logic [AW-1:0]     addr = '0;
    logic [DW-1:0]     wr_data = '0;
    logic [DW-1:0]     rd_data;
    logic              rd_valid;
    logic [NI*DW-1:0]  fpga_in = '0;
    logic [NO*DW-1:0]  fpga_out;
    logic              irq;

    io_port_ctrl #(.DATA_W(DW), .ADDR_W(AW), .N_OUT(NO), .N_IN(NI)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
        .rd_valid(rd_valid), .fpga_in(fpga_in), .fpga_out(fpga_out),
        .irq(irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cur = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got %h want %h", nm, cur, act, exp);
        end
    endtask

    // Reference model: registers as arrays, input path as pin history.
    logic [DW-1:0]    m_out [NO];
    logic [DW-1:0]    m_flag[NI];
    logic [DW-1:0]    m_mask[NI];
    logic [NI*DW-1:0] h0, h1, h2;
    int               m_edges;
    logic             m_rdv;
    logic [DW-1:0]    m_rdd;

    function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
        int g = int'(a) / 16;
        int k = int'(a) % 16;
        if (g == 0 && k < NO) return m_out[k];
        if (g == 1 && k < NI) return h1[k*DW +: DW];
        if (g == 2 && k < NI) return m_flag[k];
        if (g == 3 && k < NI) return m_mask[k];
        return '0;
    endfunction

    function automatic logic m_irq();
        logic r = 1'b0;
        for (int c = 0; c < NI; c++) r = r | (|(m_flag[c] & m_mask[c]));
        return r;
    endfunction

    function automatic logic [NO*DW-1:0] m_pins();
        logic [NO*DW-1:0] r;
        for (int c = 0; c < NO; c++) r[c*DW +: DW] = m_out[c];
        return r;
    endfunction

    task automatic model_edge();
        int g = int'(addr) / 16;
        int k = int'(addr) % 16;
        logic [NI*DW-1:0] rise;
        if (reset) begin
            for (int c = 0; c < NO; c++) m_out[c] = '0;
            for (int c = 0; c < NI; c++) begin
                m_flag[c] = '0;
                m_mask[c] = '0;
            end
            h0 = '0; h1 = '0; h2 = '0;
            m_edges = 0;
            m_rdv = 1'b0;
            m_rdd = '0;
        end else begin
            if (rd_en) m_rdd = m_read(addr);
            m_rdv = rd_en;
            rise = (m_edges >= 3) ? (h1 & ~h2) : '0;
            for (int c = 0; c < NI; c++) begin
                logic [DW-1:0] clr;
                clr = (wr_en && g == 2 && k == c) ? wr_data : '0;
                m_flag[c] = (m_flag[c] & ~clr) | rise[c*DW +: DW];
                if (wr_en && g == 3 && k == c) m_mask[c] = wr_data;
            end
            if (wr_en && g == 0 && k < NO) m_out[k] = wr_data;
            h2 = h1; h1 = h0; h0 = fpga_in;
            m_edges++;
        end
    endtask

    task automatic step(input logic r, input logic w, input logic rd,
                        input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [NI*DW-1:0] fi);
        reset = r; wr_en = w; rd_en = rd;
        addr = a; wr_data = wd; fpga_in = fi;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    typedef struct {
        logic             r, w, rd;
        logic [AW-1:0]    a;
        logic [DW-1:0]    wd;
        logic [NI*DW-1:0] fi;
        logic [NO*DW-1:0] e_out;
        logic             e_irq, e_rdv;
        logic [DW-1:0]    e_rdd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic r, w, rd,
                               input logic [7:0] a, wd,
                               input logic [15:0] fi,
                               input logic [31:0] eo,
                               input logic ei, ev,
                               input logic [7:0] ed);
        vec_t x;
        x.r = r; x.w = w; x.rd = rd; x.a = a; x.wd = wd; x.fi = fi;
        x.e_out = eo; x.e_irq = ei; x.e_rdv = ev; x.e_rdd = ed;
        return x;
    endfunction

    localparam logic [31:0] O1 = 32'h00A5_0000;
    localparam logic [31:0] O2 = 32'h00A5_2200;

    logic [7:0] alist [16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h05,
                               8'h10, 8'h11, 8'h12, 8'h20, 8'h21,
                               8'h22, 8'h30, 8'h31, 8'h32, 8'h40, 8'hFF};

    initial begin
        tbl.push_back(v(1,0,0,8'h00,8'h00,16'h0000, 0,0,0,8'h00));
        tbl.push_back(v(0,1,0,8'h02,8'hA5,16'h0000, O1,0,0,8'h00));
        tbl.push_back(v(0,0,1,8'h02,8'h00,16'h0000, O1,0,1,8'hA5));
        tbl.push_back(v(0,0,0,8'h00,8'h00,16'h0000, O1,0,0,8'hA5));
        tbl.push_back(v(0,1,0,8'h30,8'h01,16'h0000, O1,0,0,8'hA5));
        tbl.push_back(v(0,0,0,8'h00,8'h00,16'h0081, O1,0,0,8'hA5));
        tbl.push_back(v(0,0,0,8'h00,8'h00,16'h0081, O1,0,0,8'hA5));
        tbl.push_back(v(0,0,1,8'h10,8'h00,16'h0081, O1,1,1,8'h81));
        tbl.push_back(v(0,0,1,8'h20,8'h00,16'h0081, O1,1,1,8'h81));
        tbl.push_back(v(0,1,0,8'h20,8'h01,16'h0081, O1,0,0,8'h81));
        tbl.push_back(v(0,0,1,8'h20,8'h00,16'h0081, O1,0,1,8'h80));
        for (int i = 0; i < 3; i++)
            tbl.push_back(v(0,0,0,8'h00,8'h00,16'h0080, O1,0,0,8'h80));
        for (int i = 0; i < 2; i++)
            tbl.push_back(v(0,0,0,8'h00,8'h00,16'h0081, O1,0,0,8'h80));
        tbl.push_back(v(0,1,0,8'h20,8'h01,16'h0081, O1,1,0,8'h80));
        tbl.push_back(v(0,0,1,8'h20,8'h00,16'h0081, O1,1,1,8'h81));
        tbl.push_back(v(0,1,0,8'h20,8'hFF,16'h0081, O1,0,0,8'h81));
        tbl.push_back(v(0,1,0,8'h01,8'h11,16'h0081, 32'h00A5_1100,0,0,8'h81));
        tbl.push_back(v(0,1,1,8'h01,8'h22,16'h0081, O2,0,1,8'h11));
        tbl.push_back(v(0,0,1,8'h01,8'h00,16'h0081, O2,0,1,8'h22));
        tbl.push_back(v(0,0,1,8'h02,8'h00,16'h0081, O2,0,1,8'hA5));
        tbl.push_back(v(0,0,1,8'h05,8'h00,16'h0081, O2,0,1,8'h00));
        tbl.push_back(v(0,0,1,8'h02,8'h00,16'h0081, O2,0,1,8'hA5));
        tbl.push_back(v(0,0,1,8'h40,8'h00,16'h0081, O2,0,1,8'h00));
        tbl.push_back(v(0,1,0,8'h40,8'hFF,16'h0081, O2,0,0,8'h00));
        tbl.push_back(v(0,1,0,8'h04,8'hFF,16'h0081, O2,0,0,8'h00));
        tbl.push_back(v(0,1,0,8'h32,8'hFF,16'h0081, O2,0,0,8'h00));
        tbl.push_back(v(0,0,1,8'h30,8'h00,16'h0081, O2,0,1,8'h01));
        tbl.push_back(v(0,0,1,8'h12,8'h00,16'h0081, O2,0,1,8'h00));
        tbl.push_back(v(1,1,1,8'h00,8'h77,16'hFFFF, 0,0,0,8'h00));
        tbl.push_back(v(1,0,0,8'h00,8'h00,16'hFFFF, 0,0,0,8'h00));
        tbl.push_back(v(0,1,0,8'h30,8'hFF,16'hFFFF, 0,0,0,8'h00));
        tbl.push_back(v(0,1,0,8'h31,8'hFF,16'hFFFF, 0,0,0,8'h00));
        for (int i = 0; i < 5; i++)
            tbl.push_back(v(0,0,0,8'h00,8'h00,16'hFFFF, 0,0,0,8'h00));
        tbl.push_back(v(0,0,1,8'h20,8'h00,16'hFFFF, 0,0,1,8'h00));
        tbl.push_back(v(0,0,1,8'h21,8'h00,16'hFFFF, 0,0,1,8'h00));
        tbl.push_back(v(0,0,1,8'h10,8'h00,16'hFFFF, 0,0,1,8'hFF));
        tbl.push_back(v(0,0,1,8'h11,8'h00,16'hFFFF, 0,0,1,8'hFF));

        for (int i = 0; i < tbl.size(); i++) begin
            cur = i;
            step(tbl[i].r, tbl[i].w, tbl[i].rd, tbl[i].a, tbl[i].wd,
                 tbl[i].fi);
            chk("vec_fpga_out", 32'(fpga_out), 32'(tbl[i].e_out));
            chk("vec_irq", 32'(irq), 32'(tbl[i].e_irq));
            chk("vec_rd_valid", 32'(rd_valid), 32'(tbl[i].e_rdv));
            chk("vec_rd_data", 32'(rd_data), 32'(tbl[i].e_rdd));
        end

        step(1, 0, 0, 8'h00, 8'h00, 16'h0000);
        for (int i = 0; i < 2000; i++) begin
            logic [AW-1:0]    a;
            logic [NI*DW-1:0] fi;
            cur = 1000 + i;
            a  = ($urandom_range(7) == 0) ? AW'($urandom)
                                          : alist[$urandom_range(15)];
            fi = ($urandom_range(3) == 0) ? (NI*DW)'($urandom) : fpga_in;
            step($urandom_range(199) == 0, $urandom_range(2) == 0,
                 $urandom_range(1) == 0, a, DW'($urandom), fi);
            chk("rnd_fpga_out", 32'(fpga_out), 32'(m_pins()));
            chk("rnd_irq", 32'(irq), 32'(m_irq()));
            chk("rnd_rd_valid", 32'(rd_valid), 32'(m_rdv));
            chk("rnd_rd_data", 32'(rd_data), 32'(m_rdd));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
